cpu_bus_bridge: RTL

- Parametrised successor to the fixed 6502 pin wrapper. It sits between a CPU core (6502-class, RDY-stallable) and the user io pads.
- Adds registered bus cycles, programmable wait states, a selectable write-strobe shape and generic address/data widths.
- Each CPU access becomes a SETUP / HOLD / SAMPLE pad cycle. The CPU is stalled via cpu_rdy until the read data is latched.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/cpu_bus_wait_timer.sv | 30 +++
 rtl/cpu_bus_bridge.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU-to-pad bus bridge: FSM states and write-strobe shapes.
// Optional external wait (CPU_BUS_EXT_WAIT_EN) is handled in the top module.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    LAUNCH,
    SETUP,
    HOLD,
    SAMPLE,
    DONE
  } bus_state_e;

  localparam logic [1:0] STB_LEVEL    = 2'd0;
  localparam logic [1:0] STB_CLK_LOW  = 2'd1;
  localparam logic [1:0] STB_CLK_HIGH = 2'd2;
  localparam logic [1:0] STB_LATE     = 2'd3;

  function automatic logic in_window(bus_state_e s);
    return (s == SETUP) || (s == HOLD) || (s == SAMPLE);
  endfunction

endpackage

// File: rtl/cpu_bus_wait_timer.sv
// Wait-state down counter: loaded at launch, decremented while holding.
// zero/last flags steer the bridge FSM out of SETUP and HOLD.
module cpu_bus_wait_timer #(
  parameter int WSW = 3
) (
  input  logic           wb_clk_i,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dec,
  input  logic [WSW-1:0] load_val,
  output logic           zero,
  output logic           last
);

  logic [WSW-1:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == WSW'(1));

endmodule

// File: rtl/cpu_bus_bridge.sv
// Registered CPU-to-pad bus bridge with wait states and shaped write strobe.
// Define CPU_BUS_EXT_WAIT_EN to let pad_wait stretch the SAMPLE phase.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int WSW = 3
) (
  input  logic           wb_clk_i,
  input  logic           rst_n,
  input  logic [AW-1:0]  cpu_ab,
  input  logic [DW-1:0]  cpu_do,
  input  logic           cpu_we,
  output logic [DW-1:0]  cpu_di,
  output logic           cpu_rdy,
  output logic [AW-1:0]  pad_ab,
  output logic [DW-1:0]  pad_do,
  input  logic [DW-1:0]  pad_di,
  output logic           pad_we,
  output logic [DW-1:0]  pad_oeb,
  input  logic           pad_wait,
  input  logic [1:0]     strobe_mode,
  input  logic [WSW-1:0] wait_cfg
);

  bus_state_e state, state_nx;
  logic       wr;
  logic       t_zero;
  logic       t_last;
  logic       wr_act;
  logic       sample_go;

  cpu_bus_wait_timer #(.WSW(WSW)) u_timer (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .load     (state == LAUNCH),
    .dec      (state == HOLD),
    .load_val (wait_cfg),
    .zero     (t_zero),
    .last     (t_last)
  );

`ifdef CPU_BUS_EXT_WAIT_EN
  assign sample_go = !pad_wait;
`else
  logic unused_pad_wait;
  assign unused_pad_wait = pad_wait;
  assign sample_go = 1'b1;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state <= LAUNCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LAUNCH:  state_nx = SETUP;
      SETUP:   state_nx = t_zero ? SAMPLE : HOLD;
      HOLD:    if (t_last) state_nx = SAMPLE;
      SAMPLE:  if (sample_go) state_nx = DONE;
      DONE:    state_nx = LAUNCH;
      default: state_nx = LAUNCH;
    endcase
  end

  // Pad address/data stay frozen from SETUP until the next launch edge.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      pad_ab <= '0;
      pad_do <= '0;
      wr     <= 1'b0;
      cpu_di <= '0;
    end else begin
      if (state == LAUNCH) begin
        pad_ab <= cpu_ab;
        pad_do <= cpu_do;
        wr     <= cpu_we;
      end
      if (state == SAMPLE && !wr) begin
        cpu_di <= pad_di;
      end
    end
  end

  assign wr_act  = wr && in_window(state);
  assign pad_oeb = {DW{~wr_act}};
  assign cpu_rdy = (state == DONE);

  always_comb begin
    pad_we = 1'b0;
    unique case (strobe_mode)
      STB_LEVEL:    pad_we = wr_act;
      STB_CLK_LOW:  pad_we = wr_act && !wb_clk_i;
      STB_CLK_HIGH: pad_we = wr_act && wb_clk_i;
      STB_LATE:     pad_we = wr && (state == HOLD || state == SAMPLE);
      default:      pad_we = 1'b0;
    endcase
  end

endmodule
